// File: rtl/adc_lvds_ser_emu_pkg.sv
// -----------------------------------------------------------------------------
// adc_lvds_ser_emu_pkg
// Shared definitions for the ADC LVDS serializer emulator: mode encodings,
// frame geometry, frame state encodings, lane word-source select and the
// signed saturation clamp. The saturation limits match those used by the
// receiving deserializer so loopback comparisons line up.
// No ports (package).
// -----------------------------------------------------------------------------
package adc_lvds_ser_emu_pkg;

    // Output-word generation mode, sampled once per frame at the load edge.
    typedef enum logic [1:0] {
        MODE_PASS  = 2'd0,
        MODE_RAMP  = 2'd1,
        MODE_FIXED = 2'd2,
        MODE_SAT   = 2'd3
    } mode_e;

    // Top-level frame state.
    typedef enum logic [0:0] {
        ST_TRAIN = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // Where a lane takes its next 16-bit word from at the load edge.
    typedef enum logic [1:0] {
        SRC_GEN  = 2'd0,  // word generated by the top (training, ramp, fixed)
        SRC_HOLD = 2'd1,  // holding register contents
        SRC_PREV = 2'd2   // repeat of the word sent in the previous frame
    } src_e;

    // Bits per lane per frame, and the bit index where the frame clock falls.
    localparam int DESERF     = 8;
    localparam int HALFDESERF = 4;

    // Saturation limits shared with the receiver.
    localparam logic signed [15:0] PMAX_DEF = 16'sd7000;
    localparam logic signed [15:0] NMAX_DEF = -16'sd7000;

    // Clamp a two's-complement sample into [nmax, pmax].
    function automatic logic [15:0] sat_clamp(input logic [15:0]        word,
                                              input logic signed [15:0] pmax,
                                              input logic signed [15:0] nmax);
        logic signed [15:0] sample;
        sample = signed'(word);
        if (sample > pmax) begin
            return pmax;
        end else if (sample < nmax) begin
            return nmax;
        end else begin
            return word;
        end
    endfunction

endpackage

// File: rtl/adc_lvds_ser_emu_lane_ser.sv
// -----------------------------------------------------------------------------
// adc_lane_ser
// One channel of the serializer: picks the frame word at the load edge,
// optionally clamps it, remembers it for underrun repeats and shifts it out
// MSB first on two lanes (bits 15:8 and bits 7:0 in parallel).
//
// Ports:
//   clk        in  1   bit clock
//   reset      in  1   synchronous, active-high
//   load_en    in  1   load edge (last bit of the frame)
//   clamp_en   in  1   clamp the selected word to [NMAX, PMAX]
//   src_sel    in  2   word source, src_e encoding
//   gen_word   in  16  word generated by the top (training / ramp / fixed)
//   hold_word  in  16  holding register contents for this channel
//   lane       out 2   [1] = bits 15:8 serial, [0] = bits 7:0 serial
// -----------------------------------------------------------------------------
module adc_lane_ser
    import adc_lvds_ser_emu_pkg::*;
#(
    parameter logic signed [15:0] PMAX = PMAX_DEF,
    parameter logic signed [15:0] NMAX = NMAX_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_en,
    input  logic        clamp_en,
    input  logic [1:0]  src_sel,
    input  logic [15:0] gen_word,
    input  logic [15:0] hold_word,
    output logic [1:0]  lane
);

    logic [7:0]  hi_sreg_r;
    logic [7:0]  lo_sreg_r;
    logic [15:0] prev_word_r;
    logic [15:0] raw_word_s;
    logic [15:0] next_word_s;

    // Select the word for the next frame and apply the optional clamp.
    always_comb begin
        raw_word_s  = gen_word;
        next_word_s = gen_word;
        case (src_e'(src_sel))
            SRC_GEN:  raw_word_s = gen_word;
            SRC_HOLD: raw_word_s = hold_word;
            SRC_PREV: raw_word_s = prev_word_r;
            default:  raw_word_s = gen_word;
        endcase
        if (clamp_en) begin
            next_word_s = sat_clamp(raw_word_s, PMAX, NMAX);
        end else begin
            next_word_s = raw_word_s;
        end
    end

    // Shift registers and previous-word store; the stored word is the one
    // actually sent, so an underrun repeats exactly what went out last.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_sreg_r   <= 8'h00;
            lo_sreg_r   <= 8'h00;
            prev_word_r <= 16'h0000;
        end else if (load_en) begin
            hi_sreg_r   <= next_word_s[15:8];
            lo_sreg_r   <= next_word_s[7:0];
            prev_word_r <= next_word_s;
        end else begin
            hi_sreg_r   <= {hi_sreg_r[6:0], 1'b0};
            lo_sreg_r   <= {lo_sreg_r[6:0], 1'b0};
        end
    end

    assign lane = {hi_sreg_r[7], lo_sreg_r[7]};

endmodule

// File: rtl/adc_lvds_ser_emu.sv
// -----------------------------------------------------------------------------
// adc_lvds_ser_emu
// Transmit-side emulation of the ADC LVDS link: four 16-bit channels, each
// serialized on two lanes, one bit per GCLK cycle, with frame clock and data
// clock. Sends TRAIN_FRAMES training frames after reset, then pass-through,
// ramp, fixed or saturated pass-through words selected by `mode`.
//
// Ports:
//   GCLK          in  1   bit clock, one serial bit per cycle
//   RESET         in  1   synchronous, active-high
//   mode          in  2   0 pass, 1 ramp, 2 fixed TEST_WORD, 3 pass + clamp
//   in_valid      in  1   data_X_in valid
//   in_ready      out 1   holding register empty (always 1 in modes 1, 2)
//   data_X_in     in  16  channel samples, two's complement (X = A..D)
//   DCHX_out      out 2   [1] bits 15:8, [0] bits 7:0, MSB first
//   FCLK_out      out 1   high for bits 0-3 of the frame, low for bits 4-7
//   DCLK_out      out 1   data clock, high on odd bit positions
//   training      out 1   training frames in progress
//   underrun_cnt  out 16  frames that repeated the previous word, saturating
//
// RAMP_SEED is the reset value of the ramp generator; 0 in normal use.
// -----------------------------------------------------------------------------
module adc_lvds_ser_emu
    import adc_lvds_ser_emu_pkg::*;
#(
    parameter int                 TRAIN_FRAMES = 16,
    parameter logic [15:0]        TRAIN_WORD   = 16'h5A3C,
    parameter logic [15:0]        TEST_WORD    = 16'hA5C3,
    parameter logic signed [15:0] PMAX         = PMAX_DEF,
    parameter logic signed [15:0] NMAX         = NMAX_DEF,
    parameter logic [15:0]        RAMP_SEED    = 16'h0000
) (
    input  logic        GCLK,
    input  logic        RESET,
    input  logic [1:0]  mode,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] data_A_in,
    input  logic [15:0] data_B_in,
    input  logic [15:0] data_C_in,
    input  logic [15:0] data_D_in,
    output logic [1:0]  DCHA_out,
    output logic [1:0]  DCHB_out,
    output logic [1:0]  DCHC_out,
    output logic [1:0]  DCHD_out,
    output logic        FCLK_out,
    output logic        DCLK_out,
    output logic        training,
    output logic [15:0] underrun_cnt
);

    localparam int             TCW           = (TRAIN_FRAMES < 1) ? 1 : $clog2(TRAIN_FRAMES + 1);
    localparam logic [TCW-1:0] TRAIN_LAST    = TCW'(TRAIN_FRAMES);
    localparam logic [2:0]     BIT_LAST      = 3'(DESERF - 1);
    localparam logic [2:0]     BIT_FCLK_FALL = 3'(HALFDESERF - 1);

    logic [2:0]     bit_cnt_r;
    logic [2:0]     bit_cnt_next_s;
    state_e         state_r;
    state_e         state_next_s;
    logic [TCW-1:0] train_cnt_r;
    logic [TCW-1:0] train_cnt_next_s;
    mode_e          mode_r;
    mode_e          mode_in_s;
    mode_e          mode_next_s;

    logic           hold_full_r;
    logic           hold_full_next_s;
    logic [15:0]    hold_r [4];
    logic [15:0]    data_in_s [4];

    logic           in_ready_r;
    logic           training_r;
    logic           fclk_r;
    logic           dclk_r;
    logic [15:0]    ramp_r;
    logic [15:0]    underrun_r;

    logic           load_s;
    logic           run_load_s;
    logic           pass_sel_s;
    logic           accept_s;
    logic           store_s;
    logic           consume_s;
    logic           underrun_s;
    logic           clamp_en_s;
    logic [1:0]     src_sel_s;
    logic [15:0]    gen_word_s [4];
    logic [1:0]     lane_s [4];

    assign data_in_s[0] = data_A_in;
    assign data_in_s[1] = data_B_in;
    assign data_in_s[2] = data_C_in;
    assign data_in_s[3] = data_D_in;

    // Frame-level strobes; `mode` is only looked at on the load edge.
    always_comb begin
        bit_cnt_next_s = bit_cnt_r + 3'd1;
        load_s         = (bit_cnt_r == BIT_LAST);
        mode_in_s      = mode_e'(mode);
        mode_next_s    = load_s ? mode_in_s : mode_r;
        run_load_s     = load_s && (state_next_s == ST_RUN);
        pass_sel_s     = (mode_in_s == MODE_PASS) || (mode_in_s == MODE_SAT);
        consume_s      = run_load_s && pass_sel_s && hold_full_r;
        underrun_s     = run_load_s && pass_sel_s && !hold_full_r;
        accept_s       = in_valid && in_ready_r;
        // Modes 1 and 2 accept and drop data, so only the pass modes store.
        store_s        = accept_s && ((mode_r == MODE_PASS) || (mode_r == MODE_SAT));
    end

    // Next state: leave training at the load edge that would start frame
    // TRAIN_FRAMES, so that very frame already carries run-mode data.
    always_comb begin
        state_next_s     = state_r;
        train_cnt_next_s = train_cnt_r;
        case (state_r)
            ST_TRAIN: begin
                if (load_s) begin
                    if (train_cnt_r == TRAIN_LAST) begin
                        state_next_s = ST_RUN;
                    end else begin
                        train_cnt_next_s = train_cnt_r + TCW'(1);
                    end
                end else begin
                    state_next_s = ST_TRAIN;
                end
            end
            ST_RUN:  state_next_s = ST_RUN;
            default: state_next_s = ST_TRAIN;
        endcase
    end

    // Holding-register occupancy. Store and consume cannot coincide: in the
    // pass modes a store needs an empty register and a consume a full one.
    always_comb begin
        hold_full_next_s = hold_full_r;
        if (store_s) begin
            hold_full_next_s = 1'b1;
        end else if (consume_s) begin
            hold_full_next_s = 1'b0;
        end else begin
            hold_full_next_s = hold_full_r;
        end
    end

    // Word source for the frame about to be loaded, common to all channels
    // except the per-channel ramp offset.
    always_comb begin
        src_sel_s  = SRC_GEN;
        clamp_en_s = 1'b0;
        for (int k = 0; k < 4; k++) begin
            gen_word_s[k] = TRAIN_WORD;
        end
        if (state_next_s == ST_RUN) begin
            case (mode_in_s)
                MODE_PASS, MODE_SAT: begin
                    src_sel_s  = hold_full_r ? SRC_HOLD : SRC_PREV;
                    clamp_en_s = (mode_in_s == MODE_SAT);
                end
                MODE_RAMP: begin
                    for (int k = 0; k < 4; k++) begin
                        gen_word_s[k] = ramp_r + 16'(k);
                    end
                end
                MODE_FIXED: begin
                    for (int k = 0; k < 4; k++) begin
                        gen_word_s[k] = TEST_WORD;
                    end
                end
                default: begin
                    src_sel_s = SRC_GEN;
                end
            endcase
        end else begin
            src_sel_s = SRC_GEN;
        end
    end

    // Bit counter, frame state, sampled mode and training flag.
    always_ff @(posedge GCLK) begin
        if (RESET) begin
            bit_cnt_r   <= BIT_LAST;
            state_r     <= ST_TRAIN;
            train_cnt_r <= '0;
            mode_r      <= MODE_PASS;
            training_r  <= 1'b1;
        end else begin
            bit_cnt_r   <= bit_cnt_next_s;
            state_r     <= state_next_s;
            train_cnt_r <= train_cnt_next_s;
            mode_r      <= mode_next_s;
            training_r  <= (state_next_s == ST_TRAIN);
        end
    end

    // Holding register and its handshake; in_ready mirrors the next
    // occupancy so it is registered yet never stale.
    always_ff @(posedge GCLK) begin
        if (RESET) begin
            hold_full_r <= 1'b0;
            in_ready_r  <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                hold_r[k] <= 16'h0000;
            end
        end else begin
            hold_full_r <= hold_full_next_s;
            in_ready_r  <= (mode_next_s == MODE_RAMP) || (mode_next_s == MODE_FIXED) ||
                           !hold_full_next_s;
            if (store_s) begin
                for (int k = 0; k < 4; k++) begin
                    hold_r[k] <= data_in_s[k];
                end
            end
        end
    end

    // Frame clock, data clock, ramp generator and underrun counter.
    // DCLK follows the low bit of the counter it is about to hold, so it is
    // high on odd bit positions and toggles on every edge in steady state.
    always_ff @(posedge GCLK) begin
        if (RESET) begin
            fclk_r     <= 1'b0;
            dclk_r     <= 1'b0;
            ramp_r     <= RAMP_SEED;
            underrun_r <= 16'h0000;
        end else begin
            if (load_s) begin
                fclk_r <= 1'b1;
            end else if (bit_cnt_r == BIT_FCLK_FALL) begin
                fclk_r <= 1'b0;
            end
            dclk_r <= bit_cnt_next_s[0];
            if (run_load_s && (mode_in_s == MODE_RAMP)) begin
                ramp_r <= ramp_r + 16'd1;
            end
            if (underrun_s && (underrun_r != 16'hFFFF)) begin
                underrun_r <= underrun_r + 16'd1;
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        adc_lane_ser #(
            .PMAX (PMAX),
            .NMAX (NMAX)
        ) u_lane (
            .clk       (GCLK),
            .reset     (RESET),
            .load_en   (load_s),
            .clamp_en  (clamp_en_s),
            .src_sel   (src_sel_s),
            .gen_word  (gen_word_s[g]),
            .hold_word (hold_r[g]),
            .lane      (lane_s[g])
        );
    end

    assign DCHA_out     = lane_s[0];
    assign DCHB_out     = lane_s[1];
    assign DCHC_out     = lane_s[2];
    assign DCHD_out     = lane_s[3];
    assign FCLK_out     = fclk_r;
    assign DCLK_out     = dclk_r;
    assign in_ready     = in_ready_r;
    assign training     = training_r;
    assign underrun_cnt = underrun_r;

endmodule

// File: tb/tb_adc_lvds_ser_emu.sv
// -----------------------------------------------------------------------------
// tb_adc_lvds_ser_emu
// Directed bench for adc_lvds_ser_emu. Frames are captured bit by bit from the
// lanes and reassembled into {A,B,C,D} 64-bit words for comparison against
// hand-computed values. The ramp generator is started at 16'hFFFC so that its
// wrap is reached within a few frames.
// -----------------------------------------------------------------------------
module tb_adc_lvds_ser_emu;

    logic        GCLK = 1'b0;
    logic        RESET;
    logic [1:0]  mode;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_A_in, data_B_in, data_C_in, data_D_in;
    logic [1:0]  DCHA_out, DCHB_out, DCHC_out, DCHD_out;
    logic        FCLK_out;
    logic        DCLK_out;
    logic        training;
    logic [15:0] underrun_cnt;

    int total = 0;
    int bad   = 0;

    // Results of the last captured frame.
    logic [63:0] frame;
    logic [7:0]  fpat, dpat;
    logic        trn, rdy;
    logic [15:0] ucnt;

    localparam logic [63:0] TRAIN_FRAME = 64'h5A3C_5A3C_5A3C_5A3C;
    localparam logic [63:0] FIXED_FRAME = 64'hA5C3_A5C3_A5C3_A5C3;
    localparam logic [63:0] UND_WORD    = 64'h00AA_0011_0022_0033;
    localparam logic [63:0] NEW_WORD    = 64'h0BEE_0CAF_0DAD_0FED;
    localparam logic [63:0] PASS_SET [4] = '{64'h1234_8001_0000_FFFF, 64'hFFFF_1234_8001_0000,
                                             64'h0000_FFFF_1234_8001, 64'h8001_0000_FFFF_1234};
    localparam logic [63:0] SAT_IN   [3] = '{64'h2328_E0C0_0064_FF9C, 64'h1B58_E4A8_1B59_E4A7,
                                             64'h8000_7FFF_0000_FFFF};
    localparam logic [63:0] SAT_EXP  [3] = '{64'h1B58_E4A8_0064_FF9C, 64'h1B58_E4A8_1B58_E4A8,
                                             64'hE4A8_1B58_0000_FFFF};
    localparam logic [63:0] RAMP_EXP [5] = '{64'hFFFC_FFFD_FFFE_FFFF, 64'hFFFD_FFFE_FFFF_0000,
                                             64'hFFFE_FFFF_0000_0001, 64'hFFFF_0000_0001_0002,
                                             64'h0000_0001_0002_0003};

    adc_lvds_ser_emu #(
        .RAMP_SEED (16'hFFFC)
    ) dut (
        .GCLK         (GCLK),
        .RESET        (RESET),
        .mode         (mode),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .data_A_in    (data_A_in),
        .data_B_in    (data_B_in),
        .data_C_in    (data_C_in),
        .data_D_in    (data_D_in),
        .DCHA_out     (DCHA_out),
        .DCHB_out     (DCHB_out),
        .DCHC_out     (DCHC_out),
        .DCHD_out     (DCHD_out),
        .FCLK_out     (FCLK_out),
        .DCLK_out     (DCLK_out),
        .training     (training),
        .underrun_cnt (underrun_cnt)
    );

    always #5 GCLK = ~GCLK;

    task automatic step();
        @(posedge GCLK);
        #1;
    endtask

    // Capture one frame starting at its bit-0 cycle; ends at bit 0 of the
    // next frame. Optionally offers a sample set from cycle snd_at and
    // changes mode at cycle mode_at (-1 = no change).
    task automatic run_frame(input logic snd, input int snd_at, input logic [63:0] words,
                             input int mode_at, input logic [1:0] mode_val);
        logic pend;
        logic acc;
        pend = 1'b0;
        {data_A_in, data_B_in, data_C_in, data_D_in} = words;
        frame = '0;
        fpat  = '0;
        dpat  = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == mode_at) mode = mode_val;
            if (snd && (i == snd_at)) pend = 1'b1;
            in_valid = pend;
            if (i == 0) begin
                trn  = training;
                rdy  = in_ready;
                ucnt = underrun_cnt;
            end
            frame[63-i] = DCHA_out[1];
            frame[55-i] = DCHA_out[0];
            frame[47-i] = DCHB_out[1];
            frame[39-i] = DCHB_out[0];
            frame[31-i] = DCHC_out[1];
            frame[23-i] = DCHC_out[0];
            frame[15-i] = DCHD_out[1];
            frame[7-i]  = DCHD_out[0];
            fpat[7-i]   = FCLK_out;
            dpat[7-i]   = DCLK_out;
            acc = pend && in_ready;
            step();
            if (acc) pend = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) step();
        total++;
        if ({DCHA_out, DCHB_out, DCHC_out, DCHD_out, FCLK_out, DCLK_out} !== 10'h000) begin
            bad++;
            $display("FAIL reset_lanes: got %h want 000",
                     {DCHA_out, DCHB_out, DCHC_out, DCHD_out, FCLK_out, DCLK_out});
        end
        total++;
        if ({in_ready, training, underrun_cnt} !== {1'b0, 1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL reset_status: got rdy=%b trn=%b ucnt=%h want 0 1 0000",
                     in_ready, training, underrun_cnt);
        end
        RESET = 1'b0;
        total++;
        if (in_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_after_release: got %b want 0", in_ready);
        end
        step();
    endtask

    // Frames 0..15 are training; the first pass-through set is offered in
    // frame 15 so the first run frame has data waiting.
    task automatic test_training();
        for (int f = 0; f < 16; f++) begin
            run_frame(f == 15, 0, PASS_SET[0], -1, 2'd0);
            total++;
            if (frame !== TRAIN_FRAME) begin
                bad++;
                $display("FAIL train_frame%0d: got %h want %h", f, frame, TRAIN_FRAME);
            end
            total++;
            if (trn !== 1'b1) begin
                bad++;
                $display("FAIL train_flag%0d: got %b want 1", f, trn);
            end
            if (f == 0) begin
                total++;
                if ({fpat, dpat} !== {8'b1111_0000, 8'b0101_0101}) begin
                    bad++;
                    $display("FAIL train_clocks: got fclk=%b dclk=%b want 11110000 01010101",
                             fpat, dpat);
                end
                total++;
                if (rdy !== 1'b1) begin
                    bad++;
                    $display("FAIL ready_rise: got %b want 1", rdy);
                end
            end
        end
    endtask

    // Back-to-back pass-through frames; the last call switches to mode 3
    // and offers the first saturation set.
    task automatic test_pass_through();
        for (int i = 0; i < 4; i++) begin
            run_frame(1'b1, 0, (i < 3) ? PASS_SET[i+1] : SAT_IN[0], (i == 3) ? 0 : -1, 2'd3);
            total++;
            if (frame !== PASS_SET[i]) begin
                bad++;
                $display("FAIL pass%0d: got %h want %h", i, frame, PASS_SET[i]);
            end
            total++;
            if ({trn, ucnt} !== {1'b0, 16'h0000}) begin
                bad++;
                $display("FAIL pass_status%0d: got trn=%b ucnt=%h want 0 0000", i, trn, ucnt);
            end
        end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 3; i++) begin
            run_frame(1'b1, 0, (i < 2) ? SAT_IN[i+1] : UND_WORD, (i == 2) ? 0 : -1, 2'd0);
            total++;
            if (frame !== SAT_EXP[i]) begin
                bad++;
                $display("FAIL sat%0d: got %h want %h", i, frame, SAT_EXP[i]);
            end
        end
        total++;
        if (ucnt !== 16'h0000) begin
            bad++;
            $display("FAIL sat_ucnt: got %h want 0000", ucnt);
        end
    endtask

    // 00AA set is sent once, then repeats; a set offered exactly on the
    // load edge still leaves that frame as an underrun.
    task automatic test_underrun();
        for (int i = 0; i < 5; i++) begin
            run_frame(i == 3, 7, NEW_WORD, -1, 2'd0);
            total++;
            if (frame !== UND_WORD) begin
                bad++;
                $display("FAIL under%0d: got %h want %h", i, frame, UND_WORD);
            end
            total++;
            if (ucnt !== 16'(i)) begin
                bad++;
                $display("FAIL under_cnt%0d: got %h want %h", i, ucnt, 16'(i));
            end
        end
        total++;
        if (rdy !== 1'b0) begin
            bad++;
            $display("FAIL under_ready: got %b want 0", rdy);
        end
        run_frame(1'b0, 0, 64'h0, 0, 2'd1);
        total++;
        if ({frame, ucnt} !== {NEW_WORD, 16'h0004}) begin
            bad++;
            $display("FAIL under_late: got %h/%h want %h/0004", frame, ucnt, NEW_WORD);
        end
    endtask

    task automatic test_ramp_wrap();
        for (int j = 0; j < 4; j++) begin
            run_frame(j == 0, 0, 64'h1111_2222_3333_4444, -1, 2'd1);
            total++;
            if (frame !== RAMP_EXP[j]) begin
                bad++;
                $display("FAIL ramp%0d: got %h want %h", j, frame, RAMP_EXP[j]);
            end
        end
        total++;
        if ({rdy, ucnt} !== {1'b1, 16'h0004}) begin
            bad++;
            $display("FAIL ramp_status: got rdy=%b ucnt=%h want 1 0004", rdy, ucnt);
        end
    endtask

    task automatic test_mode_change();
        run_frame(1'b0, 0, 64'h0, 2, 2'd2);
        total++;
        if (frame !== RAMP_EXP[4]) begin
            bad++;
            $display("FAIL mode_inflight: got %h want %h", frame, RAMP_EXP[4]);
        end
        run_frame(1'b0, 0, 64'h0, -1, 2'd2);
        total++;
        if (frame !== FIXED_FRAME) begin
            bad++;
            $display("FAIL mode_fixed: got %h want %h", frame, FIXED_FRAME);
        end
        total++;
        if ({fpat, dpat, rdy} !== {8'b1111_0000, 8'b0101_0101, 1'b1}) begin
            bad++;
            $display("FAIL fixed_clocks: got %b %b %b want 11110000 01010101 1", fpat, dpat, rdy);
        end
    endtask

    task automatic test_mid_frame_reset();
        repeat (5) step();
        RESET = 1'b1;
        step();
        total++;
        if ({DCHA_out, DCHB_out, DCHC_out, DCHD_out, FCLK_out, DCLK_out} !== 10'h000) begin
            bad++;
            $display("FAIL midreset_lanes: got %h want 000",
                     {DCHA_out, DCHB_out, DCHC_out, DCHD_out, FCLK_out, DCLK_out});
        end
        total++;
        if ({in_ready, training, underrun_cnt} !== {1'b0, 1'b1, 16'h0000}) begin
            bad++;
            $display("FAIL midreset_status: got rdy=%b trn=%b ucnt=%h want 0 1 0000",
                     in_ready, training, underrun_cnt);
        end
        step();
        RESET = 1'b0;
        step();
        run_frame(1'b0, 0, 64'h0, -1, 2'd2);
        total++;
        if ({frame, trn, fpat} !== {TRAIN_FRAME, 1'b1, 8'b1111_0000}) begin
            bad++;
            $display("FAIL retrain: got %h trn=%b fclk=%b want %h 1 11110000",
                     frame, trn, fpat, TRAIN_FRAME);
        end
    endtask

    initial begin
        RESET     = 1'b1;
        mode      = 2'd0;
        in_valid  = 1'b0;
        data_A_in = 16'h0000;
        data_B_in = 16'h0000;
        data_C_in = 16'h0000;
        data_D_in = 16'h0000;
        test_reset();
        test_training();
        test_pass_through();
        test_saturation();
        test_underrun();
        test_ramp_wrap();
        test_mode_change();
        test_mid_frame_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
